pc_unit: RTL and testbench

Program counter datapath for the SM83 core, directly downstream of the control FSM, which drives its strobes. Holds the 16-bit PC and drives it onto the shared address bus. It also supports:
- a two-cycle increment (tap, then commit);
- direct 16-bit writes from the address bus;
- little-endian byte-assembled loads from the data bus (JP a16);
- optionally, signed relative jumps (JR e8).

Illegal strobe combinations are caught in a sticky error flag.

---
 rtl/cpu_defs_pkg.sv | 40 ++++
 rtl/pc_unit_stage.sv | 77 +++++++
 rtl/pc_unit.sv | 126 ++++++++++++
 tb/tb_pc_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared SM83 core definitions: staging-FSM encodings, reset vector,
// register selectors used by the control FSM, and a byte sign-extension helper.
package cpu_defs;

    // PC value loaded on reset
    localparam logic [15:0] RESET_VEC = 16'h0000;

    // JP a16 byte-staging states
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // 8-bit register selectors (opcode field order)
    typedef enum logic [2:0] {
        REG_B      = 3'd0,
        REG_C      = 3'd1,
        REG_D      = 3'd2,
        REG_E      = 3'd3,
        REG_H      = 3'd4,
        REG_L      = 3'd5,
        REG_HL_IND = 3'd6,
        REG_A      = 3'd7
    } reg8_e;

    // 16-bit register pair selectors
    typedef enum logic [1:0] {
        RP_BC = 2'd0,
        RP_DE = 2'd1,
        RP_HL = 2'd2,
        RP_SP = 2'd3
    } reg16_e;

    // Sign-extend a relative displacement byte to 16 bits
    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/pc_unit_stage.sv
// pc_stage: JP a16 byte-staging FSM with lo/hi byte registers.
// Reports the assembled {hi,lo}, a full flag, a one-cycle illegal-op pulse and
// a commit pulse when a 16-bit load is accepted.
module pc_stage
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ldl_i,
    input  logic        ldh_i,
    input  logic        ld16_i,
    input  logic        freeze_i,
    input  logic [7:0]  data_i,
    output logic [15:0] stage_o,
    output logic        full_o,
    output logic        illegal_o,
    output logic        commit_o
);

    stage_state_e state_q, state_d;
    logic [7:0]   lo_q, lo_d;
    logic [7:0]   hi_q, hi_d;

    // State and byte registers; reset discards any partially staged address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state and byte-load decode; a 16-bit load takes precedence and
    // drops any byte strobe in the same cycle
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        illegal_o = 1'b0;
        commit_o  = 1'b0;
        if (!freeze_i) begin
            if (ld16_i) begin
                if (state_q == ST_FULL) begin
                    commit_o = 1'b1;
                    state_d  = ST_EMPTY;
                end else begin
                    illegal_o = 1'b1;
                end
            end else if (ldl_i && ldh_i) begin
                illegal_o = 1'b1;
            end else if (ldl_i) begin
                lo_d = data_i;
                if (state_q == ST_EMPTY) begin
                    state_d = ST_LO;
                end
            end else if (ldh_i) begin
                case (state_q)
                    ST_EMPTY: illegal_o = 1'b1;
                    ST_LO: begin
                        hi_d    = data_i;
                        state_d = ST_FULL;
                    end
                    ST_FULL:  hi_d = data_i;
                    default:  state_d = ST_EMPTY;
                endcase
            end
        end
    end

    assign stage_o = {hi_q, lo_q};
    assign full_o  = (state_q == ST_FULL);

endmodule

// File: rtl/pc_unit.sv
// pc_unit: SM83 program counter datapath. Holds the PC, drives it onto the
// shared address bus, and supports tap/commit increment, direct bus writes,
// JP a16 byte-assembled loads and (with PC_REL_JUMP_EN defined) JR e8.
// Without PC_REL_JUMP_EN, pc_rel_en only raises the sticky error flag.
module pc_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] addr_bus,
    input  logic [7:0]  data_bus,
    input  logic        pc_oe,
    input  logic        pc_wr,
    input  logic        pc_inc_tap_en,
    input  logic        pc_inc_en,
    input  logic        pc_ldl,
    input  logic        pc_ldh,
    input  logic        pc_ld16,
    input  logic        pc_rel_en,
    output logic [15:0] pc_q,
    output logic        stage_full,
    output logic        pc_err
);

    logic [15:0] pc_d;
    logic        pc_upd;
    logic        err_set;
    logic [15:0] tap_q;
    logic        tap_valid_q;
    logic        multi_wr;
    logic [15:0] stage_val;
    logic        stage_illegal;
    logic        stage_commit;

    // More than one PC write source in a cycle is rejected as a whole
    assign multi_wr = (pc_wr & pc_ld16) | (pc_wr & pc_rel_en) | (pc_ld16 & pc_rel_en);

    pc_stage u_stage (
        .clk       (clk),
        .rst       (rst),
        .ldl_i     (pc_ldl),
        .ldh_i     (pc_ldh),
        .ld16_i    (pc_ld16),
        .freeze_i  (multi_wr),
        .data_i    (data_bus),
        .stage_o   (stage_val),
        .full_o    (stage_full),
        .illegal_o (stage_illegal),
        .commit_o  (stage_commit)
    );

    // Write-source selection and illegal-combination detection
    always_comb begin
        pc_d    = pc_q;
        pc_upd  = 1'b0;
        err_set = stage_illegal;
        if (multi_wr) begin
            err_set = 1'b1;
        end else if (pc_wr) begin
            if (pc_inc_en) begin
                if (tap_valid_q) begin
                    pc_d   = tap_q;
                    pc_upd = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end else if (pc_oe) begin
                // We would be reading our own drive back off the bus
                err_set = 1'b1;
            end else begin
                pc_d   = addr_bus;
                pc_upd = 1'b1;
            end
        end else if (pc_ld16) begin
            if (stage_commit) begin
                pc_d   = stage_val;
                pc_upd = 1'b1;
            end
        end else if (pc_rel_en) begin
`ifdef PC_REL_JUMP_EN
            pc_d   = pc_q + sext8(data_bus);
            pc_upd = 1'b1;
`else
            err_set = 1'b1;
`endif
        end
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else if (pc_upd) begin
            pc_q <= pc_d;
        end
    end

    // Increment tap; any PC update invalidates it, even one in the tap cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q       <= 16'h0000;
            tap_valid_q <= 1'b0;
        end else begin
            if (pc_inc_tap_en) begin
                tap_q <= pc_q + 16'd1;
            end
            if (pc_upd) begin
                tap_valid_q <= 1'b0;
            end else if (pc_inc_tap_en) begin
                tap_valid_q <= 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_err <= 1'b0;
        end else if (err_set) begin
            pc_err <= 1'b1;
        end
    end

    assign addr_bus = pc_oe ? pc_q : 16'hzzzz;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed vectors push expected state into a
// queue; a monitor on the falling edge pops and compares.
module tb_pc_unit;

    localparam logic [7:0] S_NONE = 8'h00;
    localparam logic [7:0] S_OE   = 8'h80;
    localparam logic [7:0] S_WR   = 8'h40;
    localparam logic [7:0] S_TAP  = 8'h20;
    localparam logic [7:0] S_INC  = 8'h10;
    localparam logic [7:0] S_LDL  = 8'h08;
    localparam logic [7:0] S_LDH  = 8'h04;
    localparam logic [7:0] S_LD16 = 8'h02;
    localparam logic [7:0] S_REL  = 8'h01;

    typedef struct packed {
        logic [15:0] pc;
        logic        full;
        logic        err;
        logic        oe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] addr_bus;
    logic [7:0]  data_bus;
    logic        pc_oe, pc_wr, pc_inc_tap_en, pc_inc_en;
    logic        pc_ldl, pc_ldh, pc_ld16, pc_rel_en;
    logic [15:0] pc_q;
    logic        stage_full, pc_err;
    logic        drv_en;
    logic [15:0] drv_val;

    exp_t  sb[$];
    string nq[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    assign addr_bus = drv_en ? drv_val : 16'hzzzz;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .pc_oe         (pc_oe),
        .pc_wr         (pc_wr),
        .pc_inc_tap_en (pc_inc_tap_en),
        .pc_inc_en     (pc_inc_en),
        .pc_ldl        (pc_ldl),
        .pc_ldh        (pc_ldh),
        .pc_ld16       (pc_ld16),
        .pc_rel_en     (pc_rel_en),
        .pc_q          (pc_q),
        .stage_full    (stage_full),
        .pc_err        (pc_err)
    );

    task automatic chk(input string nm, input string what,
                       input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    // Monitor: compare one expected entry per falling edge once available
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = nq.pop_front();
            chk(nm, "pc", pc_q, e.pc);
            chk(nm, "full", {15'd0, stage_full}, {15'd0, e.full});
            chk(nm, "err", {15'd0, pc_err}, {15'd0, e.err});
            // With pc_oe low the bench parks 0000 on the bus; a stray DUT drive
            // of a nonzero PC would corrupt it
            chk(nm, "addr", addr_bus, e.oe ? e.pc : 16'h0000);
            $display("txn %-16s pc=%h full=%0d err=%0d addr=%h", nm, pc_q, stage_full, pc_err, addr_bus);
        end
    end

    // One strobe cycle followed by an idle cycle in which the result is checked
    task automatic step(input string nm, input logic [7:0] s, input logic [7:0] d,
                        input logic drv, input logic [15:0] av, input logic rst_p,
                        input logic idle_oe, input logic [15:0] epc,
                        input logic efull, input logic eerr);
        exp_t e;
        @(posedge clk); #1;
        rst           = rst_p;
        pc_oe         = s[7];
        pc_wr         = s[6];
        pc_inc_tap_en = s[5];
        pc_inc_en     = s[4];
        pc_ldl        = s[3];
        pc_ldh        = s[2];
        pc_ld16       = s[1];
        pc_rel_en     = s[0];
        data_bus      = d;
        drv_en        = drv;
        drv_val       = av;
        @(posedge clk); #1;
        rst           = 1'b0;
        {pc_wr, pc_inc_tap_en, pc_inc_en, pc_ldl, pc_ldh, pc_ld16, pc_rel_en} = 7'd0;
        pc_oe         = idle_oe;
        drv_en        = ~idle_oe;
        drv_val       = 16'h0000;
        e.pc   = epc;
        e.full = efull;
        e.err  = eerr;
        e.oe   = idle_oe;
        sb.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic rst_step(input string nm);
        step(nm, S_NONE, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        {pc_oe, pc_wr, pc_inc_tap_en, pc_inc_en, pc_ldl, pc_ldh, pc_ld16, pc_rel_en} = 8'd0;
        data_bus = 8'h00;
        drv_en   = 1'b0;
        drv_val  = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        pc_oe = 1'b1;

        // name            strobes        data   drv   bus       rst   ioe   pc        full  err
        step("reset_state",  S_NONE,        8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step("wr_ffff",      S_WR,          8'h00, 1'b1, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        step("bus_release",  S_NONE,        8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        step("tap_ffff",     S_TAP,         8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        step("commit_wrap",  S_WR|S_INC,    8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step("commit_notap", S_WR|S_INC,    8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        rst_step("rst_a");
        step("ldl_50",       S_LDL,         8'h50, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step("ldh_01",       S_LDH,         8'h01, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        step("ld16_0150",    S_LD16,        8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0150, 1'b0, 1'b0);
        step("ld16_empty",   S_LD16,        8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0150, 1'b0, 1'b1);
        rst_step("rst_b");
        step("wr_0100",      S_WR,          8'h00, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
`ifdef PC_REL_JUMP_EN
        step("rel_fe",       S_REL,         8'hFE, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0);
        step("rel_7f",       S_REL,         8'h7F, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h017D, 1'b0, 1'b0);
`else
        step("rel_fe_off",   S_REL,         8'hFE, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
        step("rel_7f_off",   S_REL,         8'h7F, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);
`endif
        rst_step("rst_c");
        step("ldl_34",       S_LDL,         8'h34, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        step("ldh_12",       S_LDH,         8'h12, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        step("wr_ld16_clash",S_WR|S_LD16,   8'h00, 1'b1, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        rst_step("rst_d");
        step("wr_1234",      S_WR,          8'h00, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        step("oe_wr_clash",  S_OE|S_WR,     8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
        rst_step("rst_e");
        step("ldh_empty",    S_LDH,         8'h77, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        rst_step("rst_f");
        step("ldl_ldh_same", S_LDL|S_LDH,   8'h11, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        rst_step("rst_g");
        step("wr_2000",      S_WR,          8'h00, 1'b1, 16'h2000, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b0);
        step("tap_and_wr",   S_TAP|S_WR,    8'h00, 1'b1, 16'h3000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b0);
        step("commit_stale", S_WR|S_INC,    8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b1);
        rst_step("rst_h");
        step("ldl_aa",       S_LDL,         8'hAA, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        rst_step("rst_in_lo");
        step("ld16_after_rst",S_LD16,       8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
